// File: rtl/seq_detector__if.sv
// Serial bit-stream bundle for seq_detector_: one data bit in, one detect flag out.
interface seq_detector__if;
  logic din;
  logic dout;

  modport master (output din, input dout);
  modport slave  (input din, output dout);
endinterface

// File: rtl/seq_detector_.sv
// Moore-style serial pattern detector. The state is the matched-prefix length, with KMP fallback on a mismatch.
// The DET state means the full pattern has matched, and dout is a registered copy of that state.
module seq_detector_ #(
  parameter logic [7:0] PATTERN = 8'b0000_0101,
  parameter int         PAT_LEN = 3,
  parameter int         OVERLAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  seq_detector__if.slave bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] DET      = 4'(PAT_LEN);
  localparam logic [8:0] PAT_MASK = 9'((32'd1 << PAT_LEN) - 32'd1);
  localparam logic [8:0] PAT9     = {1'b0, PATTERN} & PAT_MASK;

  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n_s;
  logic       din_s;
  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       dout_q;
  logic       dout_d;

  // Given k matched bits and a new bit b, find the longest prefix of the pattern
  // that is a suffix of what has been seen. A non-overlapping DET state starts again from b alone.
  function automatic logic [3:0] kmp_next(input logic [3:0] k, input logic b);
    logic [8:0] seen;
    logic [8:0] mask;
    logic [3:0] n;
    logic [3:0] best;
    if ((k == DET) && (OVERLAP == 0)) begin
      seen = {8'd0, b};
      n    = 4'd1;
    end else begin
      seen = ((PAT9 >> (PAT_LEN - int'(k))) << 1) | {8'd0, b};
      n    = k + 4'd1;
    end
    best = IDLE;
    for (int j = 1; j <= PAT_LEN; j++) begin
      mask = 9'((32'd1 << j) - 32'd1);
      best = ((j <= int'(n)) && ((seen & mask) == (PAT9 >> (PAT_LEN - j)))) ? 4'(j) : best;
    end
    return best;
  endfunction

  // Release of the reset synchroniser; assertion takes effect at once, release waits two edges.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Two-flop reset synchroniser, cleared directly by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Next-state and output decode; encodings beyond DET fall back to IDLE.
  always_comb begin
    din_s   = (bus.din === 1'b1);
    state_d = IDLE;
    dout_d  = 1'b0;
    if (state_q <= DET) begin
      state_d = kmp_next(state_q, din_s);
    end else begin
      state_d = IDLE;
    end
    dout_d = (state_d == DET);
  end

  // State and detect-flag registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= IDLE;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_seq_detector_.sv
// Directed bench for seq_detector_. It drives the default, non-overlapping and 4-bit-pattern variants in parallel.
// A bit-history model queues expected flags, and each flag is checked one edge later.
module tb_seq_detector_;

  typedef struct packed {
    logic ov;
    logic no;
    logic p4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_v = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  exp_t sb[$];

  logic [7:0] h_ov, h_no, h_p4;
  int   c_ov, c_no, c_p4;
  int   pulses_ov, pulses_no, pulses_p4;

  seq_detector__if if_ov ();
  seq_detector__if if_no ();
  seq_detector__if if_p4 ();

  assign if_ov.din = din_v;
  assign if_no.din = din_v;
  assign if_p4.din = din_v;

  seq_detector_ dut_ov (.clk(clk), .rst(rst), .bus(if_ov));
  seq_detector_ #(.PATTERN(8'b0000_0101), .PAT_LEN(3), .OVERLAP(0)) dut_no (.clk(clk), .rst(rst), .bus(if_no));
  seq_detector_ #(.PATTERN(8'b0000_1101), .PAT_LEN(4), .OVERLAP(1)) dut_p4 (.clk(clk), .rst(rst), .bus(if_p4));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shift register of the bits received so far. A match is the newest len bits equal to the pattern.
  function automatic logic model_step(input logic b, input logic [7:0] pat, input int len,
                                      input bit ovl, inout logic [7:0] hist, inout int cnt);
    logic [7:0] m;
    logic det;
    m    = 8'((32'd1 << len) - 32'd1);
    hist = {hist[6:0], b};
    cnt  = (cnt < 8) ? cnt + 1 : cnt;
    det  = (cnt >= len) && ((hist & m) == (pat & m));
    if (det && !ovl) cnt = 0;
    return det;
  endfunction

  task automatic model_reset();
    h_ov = 8'd0; h_no = 8'd0; h_p4 = 8'd0;
    c_ov = 0;    c_no = 0;    c_p4 = 0;
  endtask

  task automatic step(input logic b);
    exp_t e;
    logic be;
    @(negedge clk);
    din_v = b;
    be = (b === 1'b1);
    e.ov = model_step(be, 8'b101,  3, 1'b1, h_ov, c_ov);
    e.no = model_step(be, 8'b101,  3, 1'b0, h_no, c_no);
    e.p4 = model_step(be, 8'b1101, 4, 1'b1, h_p4, c_p4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("dout_ov", {7'd0, if_ov.dout}, {7'd0, e.ov});
    chk("dout_no", {7'd0, if_no.dout}, {7'd0, e.no});
    chk("dout_p4", {7'd0, if_p4.dout}, {7'd0, e.p4});
    pulses_ov += int'(if_ov.dout === 1'b1);
    pulses_no += int'(if_no.dout === 1'b1);
    pulses_p4 += int'(if_p4.dout === 1'b1);
  endtask

  task automatic steps(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i]);
    end
  endtask

  task automatic clear_pulses();
    pulses_ov = 0; pulses_no = 0; pulses_p4 = 0;
  endtask

  initial begin
    model_reset();
    clear_pulses();
    // The reset pulse is 10 ns wide, released between clock edges.
    #2 rst = 1'b0;
    #1;
    chk("rst_state", {4'd0, dut_ov.state_q}, 8'd0);
    chk("rst_dout",  {7'd0, if_ov.dout}, 8'd0);
    #9 rst = 1'b1;
    // The reset synchroniser takes two edges to release, so the bench drives idle zeros first.
    steps(16'b000, 3);

    clear_pulses();
    steps(16'b101, 3);
    chk("rst_then_101_pulses", 8'(pulses_ov), 8'd1);
    steps(16'b00, 2);

    clear_pulses();
    steps(16'b011_0110_0101, 11);
    chk("stream_pulses", 8'(pulses_ov), 8'd2);
    steps(16'b00, 2);

    clear_pulses();
    steps(16'b10101, 5);
    chk("overlap_pulses_ov", 8'(pulses_ov), 8'd2);
    chk("overlap_pulses_no", 8'(pulses_no), 8'd1);
    steps(16'b00, 2);

    clear_pulses();
    steps(16'b1101, 4);
    chk("fallback_1101", 8'(pulses_ov), 8'd1);
    steps(16'b00, 2);
    clear_pulses();
    steps(16'b1001, 4);
    chk("fallback_1001", 8'(pulses_ov), 8'd0);
    steps(16'b00, 2);

    clear_pulses();
    steps(16'b11101, 5);
    chk("alt_pat_pulses", 8'(pulses_p4), 8'd1);
    steps(16'b00, 2);

    // An X on din counts as 0, so 1,X,1 is a detect.
    clear_pulses();
    step(1'b1); step(1'bx); step(1'b1);
    chk("x_as_zero", 8'(pulses_ov), 8'd1);
    steps(16'b00, 2);

    // Reset in the middle of a pattern: after 1,0 the partial match must be discarded.
    step(1'b1); step(1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", {4'd0, dut_ov.state_q}, 8'd0);
    chk("mid_rst_dout",  {7'd0, if_ov.dout}, 8'd0);
    @(posedge clk); #1;
    chk("held_rst_state", {4'd0, dut_ov.state_q}, 8'd0);
    chk("held_rst_dout",  {7'd0, if_ov.dout}, 8'd0);
    @(negedge clk); #2 rst = 1'b1;
    model_reset();
    steps(16'b000, 3);
    clear_pulses();
    steps(16'b100, 3);
    chk("mid_rst_no_pulse", 8'(pulses_ov), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
